// File: rtl/model_loader.sv
// Model-programming sequencer: turns a 32-bit header/payload word stream into CSRAM and TC broadcast writes.
// Optional load checksum enabled by defining MODEL_LOADER_CHECKSUM_EN.
module model_loader #(
  parameter int NUM_CORES        = 5,
  parameter int NUM_NEURONS      = 256,
  parameter int NUM_AXONS        = 256,
  parameter int NUM_WEIGHTS      = 4,
  parameter int CSRAM_READ_WIDTH = 367,
  parameter int IN_WIDTH         = 32,
  localparam int CW = (NUM_CORES > 1)   ? $clog2(NUM_CORES)   : 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int AW = (NUM_AXONS > 1)   ? $clog2(NUM_AXONS)   : 1,
  localparam int WW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [IN_WIDTH-1:0]         in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [CSRAM_READ_WIDTH-1:0] csram_data_o,
  output logic [NW-1:0]               csram_addr_o,
  output logic [CW-1:0]               csram_core_idx_o,
  output logic                        csram_valid_o,
  output logic [WW-1:0]               tc_data_o,
  output logic [AW-1:0]               tc_addr_o,
  output logic [CW-1:0]               tc_core_idx_o,
  output logic                        tc_valid_o,
  output logic                        rst_model_o,
  output logic                        rst_network_o,
  output logic                        busy_o,
  output logic                        load_done_o,
  output logic                        idx_error_o,
  output logic                        checksum_error_o
);

  localparam int BEATS = (CSRAM_READ_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int SW    = BEATS * IN_WIDTH;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [13:0]   CORE_LIMIT = 14'(NUM_CORES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HEADER, S_PAYLOAD, S_ISSUE, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    T_NOP = 2'b00, T_CSRAM = 2'b01, T_TC = 2'b10, T_END = 2'b11
  } word_type_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic [CW-1:0]         rec_core_q, rec_core_d;
  logic [NW-1:0]         rec_addr_q, rec_addr_d;
  logic                  rec_bad_q, rec_bad_d;
  logic [CSRAM_READ_WIDTH-1:0] csram_data_q, csram_data_d;
  logic [NW-1:0]         csram_addr_q, csram_addr_d;
  logic [CW-1:0]         csram_core_q, csram_core_d;
  logic                  csram_valid_q, csram_valid_d;
  logic [WW-1:0]         tc_data_q, tc_data_d;
  logic [AW-1:0]         tc_addr_q, tc_addr_d;
  logic [CW-1:0]         tc_core_q, tc_core_d;
  logic                  tc_valid_q, tc_valid_d;
  logic                  rst_network_q, rst_network_d;
  logic                  load_done_q, load_done_d;
  logic                  idx_error_q, idx_error_d;

  word_type_e hdr_type;
  logic       hdr_bad;
  logic       accept;
  logic       enter_clear;

  assign hdr_type    = word_type_e'(in_data_i[31:30]);
  assign hdr_bad     = in_data_i[29:16] >= CORE_LIMIT;
  assign in_ready_o  = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
  assign accept      = in_valid_i && in_ready_o;
  assign enter_clear = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    beat_d        = beat_q;
    shift_d       = shift_q;
    rec_core_d    = rec_core_q;
    rec_addr_d    = rec_addr_q;
    rec_bad_d     = rec_bad_q;
    csram_data_d  = csram_data_q;
    csram_addr_d  = csram_addr_q;
    csram_core_d  = csram_core_q;
    csram_valid_d = 1'b0;
    tc_data_d     = tc_data_q;
    tc_addr_d     = tc_addr_q;
    tc_core_d     = tc_core_q;
    tc_valid_d    = 1'b0;
    rst_network_d = rst_network_q;
    load_done_d   = 1'b0;
    idx_error_d   = idx_error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (enter_clear) begin
          state_d       = S_CLEAR;
          rst_network_d = 1'b1;
          idx_error_d   = 1'b0;
        end
      end
      S_CLEAR: state_d = S_HEADER;
      S_HEADER: begin
        if (accept) begin
          case (hdr_type)
            T_NOP: ;
            T_CSRAM: begin
              rec_core_d = in_data_i[16 +: CW];
              rec_addr_d = in_data_i[0 +: NW];
              rec_bad_d  = hdr_bad;
              beat_d     = '0;
              if (hdr_bad) idx_error_d = 1'b1;
              state_d    = S_PAYLOAD;
            end
            T_TC: begin
              if (hdr_bad) begin
                idx_error_d = 1'b1;
              end else begin
                tc_core_d  = in_data_i[16 +: CW];
                tc_data_d  = in_data_i[12 +: WW];
                tc_addr_d  = in_data_i[0 +: AW];
                tc_valid_d = 1'b1;
              end
              state_d = S_ISSUE;
            end
            T_END: begin
              load_done_d   = 1'b1;
              rst_network_d = 1'b0;
              state_d       = S_DONE;
            end
            default: ;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          shift_d = {shift_q[SW-IN_WIDTH-1:0], in_data_i};
          if (beat_q == LAST_BEAT) begin
            // Out-of-range records are drained but leave the bus untouched.
            if (!rec_bad_q) begin
              csram_data_d  = shift_d[CSRAM_READ_WIDTH-1:0];
              csram_addr_d  = rec_addr_q;
              csram_core_d  = rec_core_q;
              csram_valid_d = 1'b1;
            end
            state_d = S_ISSUE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_HEADER;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      rec_core_q    <= '0;
      rec_addr_q    <= '0;
      rec_bad_q     <= 1'b0;
      csram_data_q  <= '0;
      csram_addr_q  <= '0;
      csram_core_q  <= '0;
      csram_valid_q <= 1'b0;
      tc_data_q     <= '0;
      tc_addr_q     <= '0;
      tc_core_q     <= '0;
      tc_valid_q    <= 1'b0;
      rst_network_q <= 1'b1;
      load_done_q   <= 1'b0;
      idx_error_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q       <= state_d;
      beat_q        <= beat_d;
      rec_core_q    <= rec_core_d;
      rec_addr_q    <= rec_addr_d;
      rec_bad_q     <= rec_bad_d;
      csram_data_q  <= csram_data_d;
      csram_addr_q  <= csram_addr_d;
      csram_core_q  <= csram_core_d;
      csram_valid_q <= csram_valid_d;
      tc_data_q     <= tc_data_d;
      tc_addr_q     <= tc_addr_d;
      tc_core_q     <= tc_core_d;
      tc_valid_q    <= tc_valid_d;
      rst_network_q <= rst_network_d;
      load_done_q   <= load_done_d;
      idx_error_q   <= idx_error_d;
    end
  end

  // NOTE: the payload shifter has no reset; a full record overwrites every bit before it reaches the bus.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

`ifdef MODEL_LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
  logic        csum_err_q, csum_err_d;

  always_comb begin
    csum_d     = csum_q;
    csum_err_d = csum_err_q;
    if (enter_clear) begin
      csum_d     = '0;
      csum_err_d = 1'b0;
    end else if (accept) begin
      if (state_q == S_HEADER && hdr_type == T_END) begin
        if (in_data_i[15:0] != csum_q) csum_err_d = 1'b1;
      end else begin
        csum_d = csum_q + in_data_i[15:0] + in_data_i[31:16];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
    end
  end

  assign checksum_error_o = csum_err_q;
`else
  assign checksum_error_o = 1'b0;
`endif

  assign csram_data_o     = csram_data_q;
  assign csram_addr_o     = csram_addr_q;
  assign csram_core_idx_o = csram_core_q;
  assign csram_valid_o    = csram_valid_q;
  assign tc_data_o        = tc_data_q;
  assign tc_addr_o        = tc_addr_q;
  assign tc_core_idx_o    = tc_core_q;
  assign tc_valid_o       = tc_valid_q;
  assign rst_network_o    = rst_network_q;
  assign load_done_o      = load_done_q;
  assign idx_error_o      = idx_error_q;
  assign rst_model_o      = (state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
                            (state_q == S_ISSUE)  || (state_q == S_DONE);
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: doc/model_loader.md
Name: model_loader

Overview:
- Host-facing configuration sequencer that sits directly upstream of every core's model-programming inputs.
- Consumes a 32-bit ready/valid word stream and drives the shared broadcast buses, which each core filters by core index:
  - csram_data / csram_addr / csram_core_idx / csram_valid
  - tc_data / tc_addr / tc_core_idx / tc_valid
- Owns the rst_model and rst_network sequencing around a load: it clears every core's active flag, holds the network in reset while loading, then releases it.

Parameters:
- NUM_CORES, 5, number of cores on the broadcast bus; clog2 must be ≤14.
- NUM_NEURONS, 256, CSRAM rows per core; clog2 must be ≤12.
- NUM_AXONS, 256, axons per core; clog2 must be ≤12.
- NUM_WEIGHTS, 4, weight types; clog2 must be ≤4.
- CSRAM_READ_WIDTH, 367, CSRAM row width in bits.
- IN_WIDTH, 32, stream word width; fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless the FSM is in IDLE or DONE.
- in_data  in  32  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid && in_ready.
- csram_data  out  CSRAM_READ_WIDTH  assembled CSRAM row.
- csram_addr  out  clog2(NUM_NEURONS)  CSRAM row address.
- csram_core_idx  out  clog2(NUM_CORES)  target core.
- csram_valid  out  1  one-cycle write strobe.
- tc_data  out  clog2(NUM_WEIGHTS)  axon weight-type.
- tc_addr  out  clog2(NUM_AXONS)  axon index.
- tc_core_idx  out  clog2(NUM_CORES)  target core.
- tc_valid  out  1  one-cycle write strobe.
- rst_model  out  1  model-programming enable to all cores.
- rst_network  out  1  network reset to all cores.
- busy  out  1  high from IDLE exit until DONE.
- load_done  out  1  one-cycle pulse when the END word is accepted.
- idx_error  out  1  sticky out-of-range core index.
- checksum_error  out  1  sticky checksum mismatch; tied 0 when the optional feature is disabled.

Behaviour:
- Reset values: every output is 0, except rst_network = 1. State = IDLE.
- Header word fields:
  - [31:30] type: 00 NOP, 01 CSRAM, 10 TC, 11 END.
  - [29:16] core_idx.
  - CSRAM: [11:0] neuron address.
  - TC: [15:12] data, [11:0] axon address.
  - Fields are truncated to the output widths.
- CSRAM payload:
  - BEATS = ceil(CSRAM_READ_WIDTH/32) words follow the header, first word most significant.
  - A shift register takes reg = {reg, word} per beat; csram_data is the low CSRAM_READ_WIDTH bits.
- States:
  - IDLE: in_ready = 0. On start → CLEAR.
  - CLEAR (1 cycle): rst_model = 0, rst_network = 1 → HEADER.
  - HEADER: in_ready = 1, rst_model = 1.
    - NOP: stay in HEADER.
    - CSRAM: latch header, clear beat counter → PAYLOAD.
    - TC: → ISSUE.
    - END: pulse load_done → DONE.
  - PAYLOAD: in_ready = 1. Shift on each accepted word; after beat BEATS-1 is accepted → ISSUE.
  - ISSUE (1 cycle): in_ready = 0.
    - Assert csram_valid or tc_valid for exactly this cycle, with data/addr/core_idx stable.
    - → HEADER.
  - DONE: rst_model = 1, rst_network = 0, busy = 0. On start → CLEAR.
- Timing and latency:
  - rst_network is registered: it goes 1 on the cycle CLEAR is entered and 0 on entry to DONE.
  - Strobe latency is 1 cycle after the accepting handshake (header for TC, last beat for CSRAM).
  - Minimum spacing between strobes is 2 cycles for TC and BEATS+2 cycles for CSRAM.
- Boundary conditions:
  - core_idx ≥ NUM_CORES: record is fully consumed (payload included), no strobe is issued, idx_error is set. idx_error is cleared only by rst or by entering CLEAR.
  - in_valid low mid-payload: wait indefinitely; the beat count is held.
  - start while busy: ignored.
  - Outputs other than the strobes hold their last values between strobes.
  - rst asserted mid-load: immediately returns to IDLE with reset values; the partial record is discarded.

Optional Feature:
- Macro: MODEL_LOADER_CHECKSUM_EN.
- Enabled:
  - A 16-bit accumulator clears in CLEAR and adds in_data[15:0] + in_data[31:16] (mod 2^16) for every accepted word except END.
  - END bits [15:0] carry the expected sum.
  - On mismatch, checksum_error is set (sticky until CLEAR) and load_done still pulses.
- Disabled: END bits [15:0] are ignored, checksum_error is constant 0, and no accumulator is synthesized.

Test Plan:
1. Reset then start → rst_network = 1; rst_model = 0 for exactly 1 cycle, then 1; in_ready = 1 on the following cycle.
2. TC header 0x8003_2005 (core 3, data 2, axon 5) → one cycle later tc_valid = 1, tc_core_idx = 3, tc_data = 2, tc_addr = 5; csram_valid stays 0.
3. CSRAM header 0x4001_0010 followed by 12 words (word0 = 0x0000_7FFF, words 1..11 = 0xA5A5_A5A5), with in_valid dropped for 3 cycles after beat 6:
   - csram_valid fires exactly once, 1 cycle after beat 11.
   - csram_addr = 0x10, csram_core_idx = 1.
   - csram_data[366:352] = 0x7FFF, csram_data[31:0] = 0xA5A5A5A5.
4. TC header with core_idx 7 (NUM_CORES = 5) → no tc_valid; idx_error = 1 and persists through END.
5. END word → load_done pulses 1 cycle; rst_network = 0, busy = 0. A second start re-enters CLEAR and clears idx_error.
6. rst pulled low during beat 4 of a CSRAM payload → all outputs return to reset values. A subsequent start plus a full record produces exactly one correct strobe. With MODEL_LOADER_CHECKSUM_EN, an END carrying a wrong sum sets checksum_error = 1.
